alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 32-bit combinational ALU among NUM_REQ requesters (datapath, address generator, debug port, etc.).
It latches the winner's operands and opcode, drives the ALU, registers OUT/ZERO, and returns the result with a one-cycle DONE pulse to that requester.
It sits between the control unit's requesters and the ALU instance.

---
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU among NUM_REQ requesters.
// Latency: grant at request edge, DONE one cycle after the next edge; one operation per 3 cycles.
module alu_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  OP1_IN,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  OP2_IN,
  input  logic [NUM_REQ*OPRN_WIDTH-1:0]  OPRN_IN,
  output logic [NUM_REQ-1:0]             GNT,
  output logic [NUM_REQ-1:0]             DONE,
  output logic [DATA_WIDTH-1:0]          RESULT,
  output logic                           ZERO_OUT,
  output logic                           ERR,
  output logic                           BUSY,
  output logic [DATA_WIDTH-1:0]          ALU_OP1,
  output logic [DATA_WIDTH-1:0]          ALU_OP2,
  output logic [OPRN_WIDTH-1:0]          ALU_OPRN,
  input  logic [DATA_WIDTH-1:0]          ALU_OUT,
  input  logic                           ALU_ZERO
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    zero_q, zero_d;
  logic                    err_q, err_d;
  logic                    bad_op_q, bad_op_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   op1_q, op1_d;
  logic [DATA_WIDTH-1:0]   op2_q, op2_d;
  logic [OPRN_WIDTH-1:0]   oprn_q, oprn_d;

  logic                    found;
  logic [PTR_W-1:0]        win;
  logic [OPRN_WIDTH-1:0]   win_opc;
  int                      idx;

  // Rotating scan starting at the priority pointer; first set request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
    win_opc = OPRN_IN[win*OPRN_WIDTH +: OPRN_WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    bad_op_d = bad_op_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    oprn_d   = oprn_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          op1_d      = OP1_IN[win*DATA_WIDTH +: DATA_WIDTH];
          op2_d      = OP2_IN[win*DATA_WIDTH +: DATA_WIDTH];
          // Only opcodes 1..9 are defined; anything else is sent to the ALU as 0.
          bad_op_d   = (win_opc == '0) || (win_opc > OPRN_WIDTH'(9));
          oprn_d     = bad_op_d ? '0 : win_opc;
          ptr_d      = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        result_d = bad_op_q ? '0 : ALU_OUT;
        zero_d   = bad_op_q ? 1'b0 : ALU_ZERO;
        err_d    = bad_op_q;
        done_d   = gnt_q;
        state_d  = RESP;
      end
      RESP: begin
        done_d  = '0;
        gnt_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      bad_op_q <= 1'b0;
      busy_q   <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      oprn_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      bad_op_q <= bad_op_d;
      busy_q   <= busy_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      oprn_q   <= oprn_d;
    end
  end

  assign GNT      = gnt_q;
  assign DONE     = done_q;
  assign RESULT   = result_q;
  assign ZERO_OUT = zero_q;
  assign ERR      = err_q;
  assign BUSY     = busy_q;
  assign ALU_OP1  = op1_q;
  assign ALU_OP2  = op2_q;
  assign ALU_OPRN = oprn_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a small behavioural ALU on the ALU_* ports.
module tb_alu_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 6;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [N-1:0]    REQ = '0;
  logic [N*DW-1:0] OP1_IN = '0;
  logic [N*DW-1:0] OP2_IN = '0;
  logic [N*OW-1:0] OPRN_IN = '0;
  logic [N-1:0]    GNT, DONE;
  logic [DW-1:0]   RESULT, ALU_OP1, ALU_OP2, ALU_OUT;
  logic [OW-1:0]   ALU_OPRN;
  logic            ZERO_OUT, ERR, BUSY, ALU_ZERO;

  typedef struct {
    logic [N-1:0]  done;
    logic [DW-1:0] res;
    logic          zero;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .OPRN_WIDTH(OW)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .OP1_IN(OP1_IN), .OP2_IN(OP2_IN),
    .OPRN_IN(OPRN_IN), .GNT(GNT), .DONE(DONE), .RESULT(RESULT),
    .ZERO_OUT(ZERO_OUT), .ERR(ERR), .BUSY(BUSY), .ALU_OP1(ALU_OP1),
    .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN), .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    ALU_OUT = '0;
    case (ALU_OPRN)
      6'h01: ALU_OUT = ALU_OP1 + ALU_OP2;
      6'h02: ALU_OUT = ALU_OP1 - ALU_OP2;
      6'h03: ALU_OUT = ALU_OP1 * ALU_OP2;
      6'h06: ALU_OUT = ALU_OP1 & ALU_OP2;
      6'h07: ALU_OUT = ALU_OP1 | ALU_OP2;
      default: ALU_OUT = '0;
    endcase
    ALU_ZERO = (ALU_OUT == '0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] d, input logic [DW-1:0] r, input logic z, input logic e);
    exp_t x;
    x.done = d; x.res = r; x.zero = z; x.err = e;
    sb.push_back(x);
  endtask

  task automatic issue(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [OW-1:0] opc);
    OP1_IN[idx*DW +: DW]  = a;
    OP2_IN[idx*DW +: DW]  = b;
    OPRN_IN[idx*OW +: OW] = opc;
    REQ[idx]              = 1'b1;
  endtask

  // Waits for a DONE pulse, then drops that requester's REQ at the edge that samples it.
  task automatic finish(output int who);
    bit seen = 0;
    who = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (DONE != '0) begin
        seen = 1;
        for (int i = 0; i < N; i++) if (DONE[i]) who = i;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no DONE within 20 cycles expected a DONE pulse");
    end
    @(posedge CLK); #1;
    REQ[who] = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    REQ = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  // Monitor: every DONE pulse is compared against the oldest expected response.
  logic [N-1:0] prev_done = '0;
  always @(negedge CLK) begin
    if (RST && DONE != '0) begin
      checks++;
      if (prev_done != '0) begin
        errors++;
        $display("FAIL done_width: DONE high two cycles got %0h expected 0 on second", DONE);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got DONE %0h expected none", DONE);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (DONE !== x.done || GNT !== x.done || RESULT !== x.res ||
            ZERO_OUT !== x.zero || ERR !== x.err) begin
          errors++;
          $display("FAIL resp: got done=%0h gnt=%0h res=%0h zero=%0b err=%0b expected done=%0h res=%0h zero=%0b err=%0b",
                   DONE, GNT, RESULT, ZERO_OUT, ERR, x.done, x.res, x.zero, x.err);
        end
      end
    end
    prev_done = RST ? DONE : '0;
  end

  initial begin
    int who;
    do_reset();
    check("rst_gnt", GNT, 0);
    check("rst_busy", BUSY, 0);
    check("rst_result", RESULT, 0);

    // 1: add 5+3 from requester 0
    issue(0, 5, 3, 6'h01);
    push(4'b0001, 8, 0, 0);
    @(posedge CLK); #1;
    check("t1_gnt", GNT, 4'b0001);
    check("t1_busy_exec", BUSY, 1);
    check("t1_alu_op1", ALU_OP1, 5);
    finish(who);
    check("t1_busy_idle", BUSY, 0);
    check("t1_gnt_clear", GNT, 0);
    check("t1_result_hold", RESULT, 8);

    // 2: 7-7 gives zero
    issue(1, 7, 7, 6'h02);
    push(4'b0010, 0, 1, 0);
    finish(who);

    // 4: illegal opcode
    issue(2, 11, 22, 6'h0F);
    push(4'b0100, 0, 0, 1);
    @(posedge CLK); #1;
    check("t4_alu_oprn", ALU_OPRN, 0);
    finish(who);
    check("t4_err_clear", ERR, 0);

    // 6: operand change after grant is ignored
    issue(2, 4, 2, 6'h03);
    push(4'b0100, 8, 0, 0);
    @(posedge CLK); #1;
    OP1_IN[2*DW +: DW] = 9;
    finish(who);
    check("t6_result_hold", RESULT, 8);

    // 5: reset during EXEC aborts, then requester 0 wins first
    issue(1, 7, 1, 6'h01);
    @(posedge CLK); #1;
    check("t5_gnt_pre", GNT, 4'b0010);
    #2 RST = 1'b0;
    REQ = '0;
    #1;
    check("t5_rst_gnt", GNT, 0);
    check("t5_rst_result", RESULT, 0);
    check("t5_rst_busy", BUSY, 0);
    check("t5_rst_alu", {ALU_OP1, ALU_OPRN}, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    issue(0, 100, 1, 6'h01);
    issue(1, 6'h0C, 6'h0A, 6'h06);
    push(4'b0001, 101, 0, 0);
    push(4'b0010, 8, 0, 0);
    finish(who);
    check("t5_first", who, 0);
    finish(who);
    check("t5_second", who, 1);

    // 3: all requesters held; rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) issue(i, 10 * (i + 1), i, 6'h01);
    push(4'b0001, 10, 0, 0);
    push(4'b0010, 21, 0, 0);
    push(4'b0100, 32, 0, 0);
    push(4'b1000, 43, 0, 0);
    push(4'b0001, 10, 0, 0);
    for (int t = 0; t < 5; t++) begin
      finish(who);
      if (t < 4) begin
        @(posedge CLK); #1;
        REQ[who] = 1'b1;
      end else begin
        REQ = '0;
      end
    end

    repeat (5) @(posedge CLK);
    #1;
    check("sb_empty", sb.size(), 0);
    check("final_busy", BUSY, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
